// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with byte enables, optional zero
// register, optional write-to-read bypass and a one-entry-per-cycle clear sequencer.
module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [AW-1:0]      ReadReg1,
    input  logic [AW-1:0]      ReadReg2,
    output logic [WIDTH-1:0]   ReadData1,
    output logic [WIDTH-1:0]   ReadData2,
    input  logic [AW-1:0]      WriteReg,
    input  logic [WIDTH-1:0]   WriteData,
    input  logic [WIDTH/8-1:0] WriteMask,
    input  logic               RegWrite,
    output logic               Busy
);
    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [AW-1:0]    cnt;
    logic             busyQ;
    logic             writeOk;
    logic [WIDTH-1:0] stored1;
    logic [WIDTH-1:0] stored2;

    function automatic logic inRange(input logic [AW-1:0] addr);
        return 32'(addr) < 32'(DEPTH);
    endfunction

    function automatic logic [WIDTH-1:0] mergeBytes(
        input logic [WIDTH-1:0] oldWord,
        input logic [WIDTH-1:0] newWord,
        input logic [NB-1:0]    mask
    );
        logic [WIDTH-1:0] res;
        res = oldWord;
        for (int i = 0; i < NB; i++) begin
            if (mask[i]) res[8*i +: 8] = newWord[8*i +: 8];
        end
        return res;
    endfunction

    function automatic logic [WIDTH-1:0] readSel(
        input logic [AW-1:0]    addr,
        input logic [WIDTH-1:0] stored,
        input logic             busy,
        input logic             wrOk,
        input logic [AW-1:0]    wrAddr,
        input logic [WIDTH-1:0] wrData,
        input logic [NB-1:0]    wrMask
    );
        if (busy || !inRange(addr) || (ZERO_REG && addr == '0)) return '0;
        if (BYPASS && wrOk && wrAddr == addr) return mergeBytes(stored, wrData, wrMask);
        return stored;
    endfunction

    // A write qualifies on address alone; the busy/reset gating is applied at the storage edge.
    assign writeOk = RegWrite && inRange(WriteReg) && !(ZERO_REG && WriteReg == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt   <= '0;
            busyQ <= 1'b1;
        end else if (busyQ) begin
            if (32'(cnt) == 32'(DEPTH - 1)) busyQ <= 1'b0;
            else                            cnt   <= cnt + AW'(1);
        end
    end

    // Storage has no reset of its own; the sequencer zeroes it once RST drops.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (busyQ)        regs[cnt]      <= '0;
            else if (writeOk) regs[WriteReg] <= mergeBytes(regs[WriteReg], WriteData, WriteMask);
        end
    end

    assign stored1   = regs[ReadReg1];
    assign stored2   = regs[ReadReg2];
    assign ReadData1 = readSel(ReadReg1, stored1, busyQ, writeOk, WriteReg, WriteData, WriteMask);
    assign ReadData2 = readSel(ReadReg2, stored2, busyQ, writeOk, WriteReg, WriteData, WriteMask);
    assign Busy      = busyQ;

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: default, BYPASS=0 and DEPTH=24 instances share stimulus.
module tb_regfile_param;
    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  ReadReg1, ReadReg2, WriteReg;
    logic [31:0] WriteData;
    logic [3:0]  WriteMask;
    logic        RegWrite;
    logic [31:0] rd1A, rd2A, rd1B, rd2B, rd1C, rd2C;
    logic        busyA, busyB, busyC;

    always #5 CLK = ~CLK;

    regfile_param dutA (
        .CLK(CLK), .RST(RST), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(rd1A), .ReadData2(rd2A), .WriteReg(WriteReg), .WriteData(WriteData),
        .WriteMask(WriteMask), .RegWrite(RegWrite), .Busy(busyA)
    );
    regfile_param #(.BYPASS(1'b0)) dutB (
        .CLK(CLK), .RST(RST), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(rd1B), .ReadData2(rd2B), .WriteReg(WriteReg), .WriteData(WriteData),
        .WriteMask(WriteMask), .RegWrite(RegWrite), .Busy(busyB)
    );
    regfile_param #(.DEPTH(24)) dutC (
        .CLK(CLK), .RST(RST), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(rd1C), .ReadData2(rd2C), .WriteReg(WriteReg), .WriteData(WriteData),
        .WriteMask(WriteMask), .RegWrite(RegWrite), .Busy(busyC)
    );

    typedef struct {
        int          dut;
        int          port;
        logic [31:0] exp;
        string       name;
    } sbItem_t;

    sbItem_t     sbQ[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] memA [32];
    logic [31:0] memC [24];

    function automatic logic [31:0] mergeW(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] expA(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : memA[a];
    endfunction

    function automatic logic [31:0] expC(input logic [4:0] a);
        int idx;
        idx = int'(a);
        if (idx == 0 || idx >= 24) return 32'h0;
        return memC[idx];
    endfunction

    function automatic logic [31:0] actualOf(input int dut, input int port);
        case (dut)
            0:       return (port == 1) ? rd1A : rd2A;
            1:       return (port == 1) ? rd1B : rd2B;
            default: return (port == 1) ? rd1C : rd2C;
        endcase
    endfunction

    task automatic pushExp(input int dut, input int port, input logic [31:0] e, input string name);
        sbItem_t it;
        it.dut = dut; it.port = port; it.exp = e; it.name = name;
        sbQ.push_back(it);
    endtask

    task automatic pushIdle(input logic [4:0] a1, input logic [4:0] a2, input string name);
        pushExp(0, 1, expA(a1), name); pushExp(0, 2, expA(a2), name);
        pushExp(1, 1, expA(a1), name); pushExp(1, 2, expA(a2), name);
        pushExp(2, 1, expC(a1), name); pushExp(2, 2, expC(a2), name);
    endtask

    task automatic modelWrite(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
        if (a != 5'd0) memA[a] = mergeW(memA[a], d, m);
        if (a != 5'd0 && int'(a) < 24) memC[int'(a)] = mergeW(memC[int'(a)], d, m);
    endtask

    task automatic clearModels();
        for (int i = 0; i < 32; i++) memA[i] = 32'h0;
        for (int i = 0; i < 24; i++) memC[i] = 32'h0;
    endtask

    task automatic doWrite(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge CLK);
        WriteReg = a; WriteData = d; WriteMask = m; RegWrite = 1'b1;
        @(posedge CLK); #1;
        RegWrite = 1'b0;
        modelWrite(a, d, m);
    endtask

    // Counts edges with RST low until each instance drops Busy (bounded).
    task automatic countClear(output int fA, output int fB, output int fC, input bit dropWrOnC);
        fA = 0; fB = 0; fC = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge CLK); #1;
            if (!busyA && fA == 0) fA = k;
            if (!busyB && fB == 0) fB = k;
            if (!busyC && fC == 0) fC = k;
            if (dropWrOnC && !busyC) RegWrite = 1'b0;
            if (k == 5) begin
                checks++;
                if (rd1A !== 32'h0) begin
                    failures++; $display("FAIL busy_read got=%h exp=%h", rd1A, 32'h0);
                end
            end
            if (fA != 0 && fB != 0 && fC != 0) break;
        end
        RegWrite = 1'b0;
    endtask

    task automatic test_reset();
        sbItem_t it; logic [31:0] act;
        @(negedge CLK);
        RST = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0; WriteMask = '0;
        ReadReg1 = 5'd5; ReadReg2 = 5'd17;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({busyA, busyB, busyC} !== 3'b111) begin
            failures++; $display("FAIL reset_busy got=%b exp=%b", {busyA, busyB, busyC}, 3'b111);
        end
        for (int d = 0; d < 3; d++) begin
            pushExp(d, 1, 32'h0, "reset_rd1"); pushExp(d, 2, 32'h0, "reset_rd2");
        end
        while (sbQ.size() != 0) begin
            it = sbQ.pop_front(); act = actualOf(it.dut, it.port); checks++;
            if (act !== it.exp) begin
                failures++; $display("FAIL %s dut=%0d port=%0d got=%h exp=%h", it.name, it.dut, it.port, act, it.exp);
            end
        end
    endtask

    task automatic test_clear();
        sbItem_t it; logic [31:0] act; int fA, fB, fC;
        @(negedge CLK);
        RST = 1'b0; ReadReg1 = 5'd5;
        WriteReg = 5'd5; WriteData = 32'hDEADBEEF; WriteMask = 4'hF; RegWrite = 1'b1;
        countClear(fA, fB, fC, 1'b1);
        checks++;
        if (fA !== 32) begin failures++; $display("FAIL clear_len_A got=%0d exp=%0d", fA, 32); end
        checks++;
        if (fB !== 32) begin failures++; $display("FAIL clear_len_B got=%0d exp=%0d", fB, 32); end
        checks++;
        if (fC !== 24) begin failures++; $display("FAIL clear_len_C got=%0d exp=%0d", fC, 24); end
        clearModels();
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i);
            pushIdle(ReadReg1, ReadReg2, "clear_zero");
            #1;
            while (sbQ.size() != 0) begin
                it = sbQ.pop_front(); act = actualOf(it.dut, it.port); checks++;
                if (act !== it.exp) begin
                    failures++; $display("FAIL %s dut=%0d port=%0d got=%h exp=%h", it.name, it.dut, it.port, act, it.exp);
                end
            end
        end
    endtask

    task automatic test_byte_mask();
        sbItem_t it; logic [31:0] act;
        doWrite(5'd3, 32'h11223344, 4'b1111);
        doWrite(5'd3, 32'hAABBCCDD, 4'b0101);
        @(negedge CLK);
        ReadReg1 = 5'd3; ReadReg2 = 5'd3;
        pushExp(0, 1, 32'h11BB33DD, "mask_r3");
        pushIdle(5'd3, 5'd3, "mask_r3_model");
        #1;
        while (sbQ.size() != 0) begin
            it = sbQ.pop_front(); act = actualOf(it.dut, it.port); checks++;
            if (act !== it.exp) begin
                failures++; $display("FAIL %s dut=%0d port=%0d got=%h exp=%h", it.name, it.dut, it.port, act, it.exp);
            end
        end
        doWrite(5'd3, 32'hFFFFFFFF, 4'b0000);
        @(negedge CLK);
        pushExp(0, 1, 32'h11BB33DD, "mask_zero_noop");
        pushExp(2, 2, 32'h11BB33DD, "mask_zero_noop");
        #1;
        while (sbQ.size() != 0) begin
            it = sbQ.pop_front(); act = actualOf(it.dut, it.port); checks++;
            if (act !== it.exp) begin
                failures++; $display("FAIL %s dut=%0d port=%0d got=%h exp=%h", it.name, it.dut, it.port, act, it.exp);
            end
        end
    endtask

    task automatic test_zero_reg();
        sbItem_t it; logic [31:0] act;
        @(negedge CLK);
        ReadReg1 = 5'd0; ReadReg2 = 5'd0;
        WriteReg = 5'd0; WriteData = 32'hFFFFFFFF; WriteMask = 4'hF; RegWrite = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            pushExp(d, 1, 32'h0, "zero_pre"); pushExp(d, 2, 32'h0, "zero_pre");
        end
        while (sbQ.size() != 0) begin
            it = sbQ.pop_front(); act = actualOf(it.dut, it.port); checks++;
            if (act !== it.exp) begin
                failures++; $display("FAIL %s dut=%0d port=%0d got=%h exp=%h", it.name, it.dut, it.port, act, it.exp);
            end
        end
        @(posedge CLK); #1;
        RegWrite = 1'b0;
        for (int d = 0; d < 3; d++) begin
            pushExp(d, 1, 32'h0, "zero_post"); pushExp(d, 2, 32'h0, "zero_post");
        end
        while (sbQ.size() != 0) begin
            it = sbQ.pop_front(); act = actualOf(it.dut, it.port); checks++;
            if (act !== it.exp) begin
                failures++; $display("FAIL %s dut=%0d port=%0d got=%h exp=%h", it.name, it.dut, it.port, act, it.exp);
            end
        end
    endtask

    task automatic test_bypass();
        sbItem_t it; logic [31:0] act;
        @(negedge CLK);
        ReadReg1 = 5'd6; ReadReg2 = 5'd7;
        WriteReg = 5'd7; WriteData = 32'h12345678; WriteMask = 4'hF; RegWrite = 1'b1;
        #1;
        pushExp(0, 2, 32'h12345678, "bypass_pre");
        pushExp(1, 2, 32'h00000000, "nobypass_pre");
        pushExp(2, 2, 32'h12345678, "bypass_pre_c");
        pushExp(0, 1, expA(5'd6), "bypass_other_port");
        while (sbQ.size() != 0) begin
            it = sbQ.pop_front(); act = actualOf(it.dut, it.port); checks++;
            if (act !== it.exp) begin
                failures++; $display("FAIL %s dut=%0d port=%0d got=%h exp=%h", it.name, it.dut, it.port, act, it.exp);
            end
        end
        @(posedge CLK); #1;
        RegWrite = 1'b0;
        modelWrite(5'd7, 32'h12345678, 4'hF);
        pushExp(0, 2, 32'h12345678, "bypass_post");
        pushExp(1, 2, 32'h12345678, "nobypass_post");
        while (sbQ.size() != 0) begin
            it = sbQ.pop_front(); act = actualOf(it.dut, it.port); checks++;
            if (act !== it.exp) begin
                failures++; $display("FAIL %s dut=%0d port=%0d got=%h exp=%h", it.name, it.dut, it.port, act, it.exp);
            end
        end
        @(negedge CLK);
        WriteReg = 5'd7; WriteData = 32'hAABBCCDD; WriteMask = 4'b1000; RegWrite = 1'b1;
        #1;
        pushExp(0, 2, 32'hAA345678, "bypass_partial_pre");
        pushExp(1, 2, 32'h12345678, "nobypass_partial_pre");
        while (sbQ.size() != 0) begin
            it = sbQ.pop_front(); act = actualOf(it.dut, it.port); checks++;
            if (act !== it.exp) begin
                failures++; $display("FAIL %s dut=%0d port=%0d got=%h exp=%h", it.name, it.dut, it.port, act, it.exp);
            end
        end
        @(posedge CLK); #1;
        RegWrite = 1'b0;
        modelWrite(5'd7, 32'hAABBCCDD, 4'b1000);
        pushExp(1, 2, 32'hAA345678, "nobypass_partial_post");
        while (sbQ.size() != 0) begin
            it = sbQ.pop_front(); act = actualOf(it.dut, it.port); checks++;
            if (act !== it.exp) begin
                failures++; $display("FAIL %s dut=%0d port=%0d got=%h exp=%h", it.name, it.dut, it.port, act, it.exp);
            end
        end
    endtask

    task automatic test_depth24();
        sbItem_t it; logic [31:0] act;
        doWrite(5'd27, 32'h5A5A5A5A, 4'hF);
        doWrite(5'd23, 32'hCAFEF00D, 4'hF);
        @(negedge CLK);
        ReadReg1 = 5'd27; ReadReg2 = 5'd23;
        pushExp(2, 1, 32'h0, "d24_oob_read");
        pushExp(2, 2, 32'hCAFEF00D, "d24_r23");
        pushIdle(5'd27, 5'd23, "d24_model");
        #1;
        while (sbQ.size() != 0) begin
            it = sbQ.pop_front(); act = actualOf(it.dut, it.port); checks++;
            if (act !== it.exp) begin
                failures++; $display("FAIL %s dut=%0d port=%0d got=%h exp=%h", it.name, it.dut, it.port, act, it.exp);
            end
        end
        @(negedge CLK);
        WriteReg = 5'd27; WriteData = 32'h0F0F0F0F; WriteMask = 4'hF; RegWrite = 1'b1;
        #1;
        pushExp(2, 1, 32'h0, "d24_oob_bypass");
        pushExp(0, 1, 32'h0F0F0F0F, "d32_r27_bypass");
        while (sbQ.size() != 0) begin
            it = sbQ.pop_front(); act = actualOf(it.dut, it.port); checks++;
            if (act !== it.exp) begin
                failures++; $display("FAIL %s dut=%0d port=%0d got=%h exp=%h", it.name, it.dut, it.port, act, it.exp);
            end
        end
        @(posedge CLK); #1;
        RegWrite = 1'b0;
        modelWrite(5'd27, 32'h0F0F0F0F, 4'hF);
    endtask

    task automatic test_back_to_back();
        sbItem_t it; logic [31:0] act, d; logic [3:0] m; logic [4:0] cur, prev;
        prev = 5'd3;
        for (int i = 1; i <= 8; i++) begin
            cur = 5'(8 + i);
            d = $urandom;
            m = 4'($urandom_range(1, 15));
            @(negedge CLK);
            WriteReg = cur; WriteData = d; WriteMask = m; RegWrite = 1'b1;
            ReadReg1 = prev; ReadReg2 = cur;
            #1;
            pushExp(0, 1, expA(prev), "b2b_prev");
            pushExp(1, 1, expA(prev), "b2b_prev");
            pushExp(2, 1, expC(prev), "b2b_prev");
            pushExp(0, 2, mergeW(expA(cur), d, m), "b2b_bypass");
            pushExp(1, 2, expA(cur), "b2b_nobypass");
            pushExp(2, 2, mergeW(expC(cur), d, m), "b2b_bypass");
            while (sbQ.size() != 0) begin
                it = sbQ.pop_front(); act = actualOf(it.dut, it.port); checks++;
                if (act !== it.exp) begin
                    failures++; $display("FAIL %s dut=%0d port=%0d got=%h exp=%h", it.name, it.dut, it.port, act, it.exp);
                end
            end
            @(posedge CLK); #1;
            modelWrite(cur, d, m);
            prev = cur;
        end
        RegWrite = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        sbItem_t it; logic [31:0] act; int fA, fB, fC;
        doWrite(5'd30, 32'h13579BDF, 4'hF);
        @(negedge CLK);
        ReadReg1 = 5'd30; ReadReg2 = 5'd23;
        pushIdle(5'd30, 5'd23, "preload");
        #1;
        while (sbQ.size() != 0) begin
            it = sbQ.pop_front(); act = actualOf(it.dut, it.port); checks++;
            if (act !== it.exp) begin
                failures++; $display("FAIL %s dut=%0d port=%0d got=%h exp=%h", it.name, it.dut, it.port, act, it.exp);
            end
        end
        @(negedge CLK); RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK); RST = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK); RST = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if ({busyA, busyB, busyC} !== 3'b111) begin
            failures++; $display("FAIL midclear_busy got=%b exp=%b", {busyA, busyB, busyC}, 3'b111);
        end
        @(negedge CLK); RST = 1'b0;
        countClear(fA, fB, fC, 1'b0);
        checks++;
        if (fA !== 32) begin failures++; $display("FAIL midclear_len_A got=%0d exp=%0d", fA, 32); end
        checks++;
        if (fC !== 24) begin failures++; $display("FAIL midclear_len_C got=%0d exp=%0d", fC, 24); end
        clearModels();
        @(negedge CLK);
        ReadReg1 = 5'd30; ReadReg2 = 5'd23;
        pushExp(0, 1, 32'h0, "midclear_r30");
        pushExp(2, 2, 32'h0, "midclear_r23");
        pushIdle(5'd30, 5'd23, "midclear_model");
        #1;
        while (sbQ.size() != 0) begin
            it = sbQ.pop_front(); act = actualOf(it.dut, it.port); checks++;
            if (act !== it.exp) begin
                failures++; $display("FAIL %s dut=%0d port=%0d got=%h exp=%h", it.name, it.dut, it.port, act, it.exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_byte_mask();
        test_zero_reg();
        test_bypass();
        test_depth24();
        test_back_to_back();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
